// File: rtl/load_down_counter.sv
// Loadable down-counter with prescaled ticks, IDLE/RUN/PAUSE/DONE control and a one-cycle done pulse.
// Optional periodic mode: define LOAD_DOWN_COUNTER_AUTO_RELOAD_EN to re-arm from the last loaded value.
module load_down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_num,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] number,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] number_q;
  logic             busy_q;
  logic             done_q;

`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= load_num;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    if (load) begin
      cnt_d   = load_num;
      presc_d = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cnt_q != '0) begin
              state_d = S_RUN;
              presc_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            // Saturate at zero; reaching it ends the countdown.
            if (cnt_q == WIDTH'(1) || cnt_q == '0) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            state_d = S_RUN;
            cnt_d   = reload_q;
            presc_d = '0;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      presc_q  <= '0;
      number_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      number_q <= cnt_q;
      // Decoding state_d keeps busy/done aligned with state_q.
      busy_q   <= (state_d == S_RUN) || (state_d == S_PAUSE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign number = number_q;
  assign zero   = rst_n && (number_q == '0);
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_load_down_counter.sv
// Directed bench for load_down_counter: PRESCALE=1 vector table plus a PRESCALE=3 pause sequence.
module tb_load_down_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] load_num;
  logic       start;
  logic       pause;

  logic [3:0] num1, num3;
  logic       zero1, busy1, done1;
  logic       zero3, busy3, done3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_down_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_num(load_num), .start(start), .pause(pause),
    .number(num1), .zero(zero1), .busy(busy1), .done(done1)
  );

  load_down_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_num(load_num), .start(start), .pause(pause),
    .number(num3), .zero(zero3), .busy(busy3), .done(done3)
  );

  typedef struct {
    logic       ld;
    logic [3:0] ln;
    logic       st;
    logic       pa;
    logic [3:0] e_num;
    logic       e_zero;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[40];
  vec_t p3[15];

  task automatic check(input string name, input logic [3:0] an, input logic az, input logic ab,
                       input logic ad, input logic [3:0] en, input logic ez, input logic eb,
                       input logic ed);
    n_vec++;
    if ({an, az, ab, ad} !== {en, ez, eb, ed}) begin
      n_bad++;
      $display("FAIL %s: got number=%0d zero=%0b busy=%0b done=%0b, want number=%0d zero=%0b busy=%0b done=%0b",
               name, an, az, ab, ad, en, ez, eb, ed);
    end else begin
      $display("ok   %s: number=%0d zero=%0b busy=%0b done=%0b", name, an, az, ab, ad);
    end
  endtask

  task automatic step(input logic ld, input logic [3:0] ln, input logic st, input logic pa);
    @(negedge clk);
    load     = ld;
    load_num = ln;
    start    = st;
    pause    = pa;
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic ld, input logic [3:0] ln, input logic st,
                      input logic pa, input logic [3:0] en, input logic ez, input logic eb,
                      input logic ed);
    vecs[i] = '{ld, ln, st, pa, en, ez, eb, ed};
  endtask

  task automatic setp(input int i, input logic ld, input logic [3:0] ln, input logic st,
                      input logic pa, input logic [3:0] en, input logic ez, input logic eb,
                      input logic ed);
    p3[i] = '{ld, ln, st, pa, en, ez, eb, ed};
  endtask

  initial begin
    // PRESCALE=1: countdown 5..0, abort by load 9, zero-length start, pause and ignored starts
    setv( 0, 1, 5, 0, 0,  0, 1, 0, 0);
    setv( 1, 0, 0, 1, 0,  5, 0, 1, 0);
    setv( 2, 0, 0, 0, 0,  5, 0, 1, 0);
    setv( 3, 0, 0, 0, 0,  4, 0, 1, 0);
    setv( 4, 0, 0, 0, 0,  3, 0, 1, 0);
    setv( 5, 0, 0, 0, 0,  2, 0, 1, 0);
    setv( 6, 0, 0, 0, 0,  1, 0, 0, 1);
    setv( 7, 0, 0, 0, 0,  0, 1, 0, 0);
    setv( 8, 0, 0, 0, 0,  0, 1, 0, 0);
    setv( 9, 1, 6, 0, 0,  0, 1, 0, 0);
    setv(10, 0, 0, 1, 0,  6, 0, 1, 0);
    setv(11, 0, 0, 0, 0,  6, 0, 1, 0);
    setv(12, 0, 0, 0, 0,  5, 0, 1, 0);
    setv(13, 0, 0, 0, 0,  4, 0, 1, 0);
    setv(14, 1, 9, 1, 1,  3, 0, 0, 0);
    setv(15, 0, 0, 0, 0,  9, 0, 0, 0);
    setv(16, 0, 0, 0, 0,  9, 0, 0, 0);
    setv(17, 0, 0, 1, 0,  9, 0, 1, 0);
    setv(18, 0, 0, 0, 0,  9, 0, 1, 0);
    setv(19, 0, 0, 0, 0,  8, 0, 1, 0);
    setv(20, 0, 0, 0, 0,  7, 0, 1, 0);
    setv(21, 0, 0, 0, 0,  6, 0, 1, 0);
    setv(22, 0, 0, 0, 0,  5, 0, 1, 0);
    setv(23, 0, 0, 0, 0,  4, 0, 1, 0);
    setv(24, 0, 0, 0, 0,  3, 0, 1, 0);
    setv(25, 0, 0, 0, 0,  2, 0, 1, 0);
    setv(26, 0, 0, 0, 0,  1, 0, 0, 1);
    setv(27, 0, 0, 0, 0,  0, 1, 0, 0);
    setv(28, 1, 0, 0, 0,  0, 1, 0, 0);
    setv(29, 0, 0, 1, 0,  0, 1, 0, 1);
    setv(30, 0, 0, 1, 0,  0, 1, 0, 0);
    setv(31, 0, 0, 0, 0,  0, 1, 0, 0);
    setv(32, 1, 2, 0, 0,  0, 1, 0, 0);
    setv(33, 0, 0, 1, 0,  2, 0, 1, 0);
    setv(34, 0, 0, 0, 1,  2, 0, 1, 0);
    setv(35, 0, 0, 0, 1,  2, 0, 1, 0);
    setv(36, 0, 0, 1, 0,  2, 0, 1, 0);
    setv(37, 0, 0, 1, 0,  2, 0, 1, 0);
    setv(38, 0, 0, 0, 0,  1, 0, 0, 1);
    setv(39, 0, 0, 0, 0,  0, 1, 0, 0);

    // PRESCALE=3: load 2, one tick, pause for 4 cycles, resume from held prescaler
    setp( 0, 1, 2, 0, 0,  0, 1, 0, 0);
    setp( 1, 0, 0, 1, 0,  2, 0, 1, 0);
    setp( 2, 0, 0, 0, 0,  2, 0, 1, 0);
    setp( 3, 0, 0, 0, 0,  2, 0, 1, 0);
    setp( 4, 0, 0, 0, 0,  2, 0, 1, 0);
    setp( 5, 0, 0, 0, 1,  1, 0, 1, 0);
    setp( 6, 0, 0, 0, 1,  1, 0, 1, 0);
    setp( 7, 0, 0, 0, 1,  1, 0, 1, 0);
    setp( 8, 0, 0, 0, 1,  1, 0, 1, 0);
    setp( 9, 0, 0, 0, 0,  1, 0, 1, 0);
    setp(10, 0, 0, 0, 0,  1, 0, 1, 0);
    setp(11, 0, 0, 0, 0,  1, 0, 1, 0);
    setp(12, 0, 0, 0, 0,  1, 0, 0, 1);
    setp(13, 0, 0, 0, 0,  0, 1, 0, 0);
    setp(14, 0, 0, 0, 0,  0, 1, 0, 0);

    rst_n    = 1'b0;
    load     = 1'b0;
    load_num = 4'd0;
    start    = 1'b0;
    pause    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_p1", num1, zero1, busy1, done1, 4'd0, 1'b0, 1'b0, 1'b0);
    check("reset_p3", num3, zero3, busy3, done3, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_p1", num1, zero1, busy1, done1, 4'd0, 1'b1, 1'b0, 1'b0);
    check("release_p3", num3, zero3, busy3, done3, 4'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      step(p3[i].ld, p3[i].ln, p3[i].st, p3[i].pa);
      check($sformatf("p3_seq[%0d]", i), num3, zero3, busy3, done3,
            p3[i].e_num, p3[i].e_zero, p3[i].e_busy, p3[i].e_done);
    end

    // Asynchronous reset mid-countdown clears outputs before the next edge
    step(1'b1, 4'd7, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("pre_async_rst", num1, zero1, busy1, done1, 4'd7, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", num1, zero1, busy1, done1, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      step(vecs[i].ld, vecs[i].ln, vecs[i].st, vecs[i].pa);
      check($sformatf("p1_vec[%0d]", i), num1, zero1, busy1, done1,
            vecs[i].e_num, vecs[i].e_zero, vecs[i].e_busy, vecs[i].e_done);
    end

`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0);
      check($sformatf("reload_cyc[%0d]", i), {3'b000, done1}, 1'b0, busy1, 1'b0,
            {3'b000, (i % 4) == 3}, 1'b0, (i % 4) != 3, 1'b0);
    end
    step(1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0);
      check($sformatf("reload_stop[%0d]", i), num1, zero1, busy1, done1,
            4'd0, 1'b1, 1'b0, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
